pc_seq_unit: RTL and testbench

Parametrised program-counter unit for the pipelined core. It generalises the 8-bit PC to AW-bit addresses and adds a multi-cycle vector-fetch FSM for reset and interrupts, an on-chip return-address stack (RAS) for CALL/RET/RTI, and interrupt masking. It sits at the head of the fetch stage and is driven by the execute-stage control (op, target) and the hazard unit (stall).

---
 rtl/pc_seq_pkg.sv | 24 ++
 rtl/pc_ras.sv | 50 +++++
 rtl/pc_seq_unit.sv | 126 ++++++++++++
 tb/tb_pc_seq_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op codes, FSM states
// and the return-address-stack pointer width helper.
package pc_seq_pkg;

   localparam logic [2:0] OP_HOLD  = 3'b000;
   localparam logic [2:0] OP_INC1  = 3'b001;
   localparam logic [2:0] OP_INC2  = 3'b010;
   localparam logic [2:0] OP_JUMP  = 3'b011;
   localparam logic [2:0] OP_CALL  = 3'b100;
   localparam logic [2:0] OP_RET   = 3'b101;
   localparam logic [2:0] OP_RTI   = 3'b110;
   localparam logic [2:0] OP_HOLD2 = 3'b111;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      VEC  = 2'd1,
      RUN  = 2'd2
   } state_e;

   function automatic int unsigned ras_ptr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// The ovf/unf outputs are single-cycle pulses qualified by push/pop.
module pc_ras
   import pc_seq_pkg::*;
#(
   parameter int unsigned AW        = 8,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] push_data,
   output logic [AW-1:0] pop_data,
   output logic          full,
   output logic          empty,
   output logic          ovf,
   output logic          unf
);

   localparam int unsigned PW = ras_ptr_w(RAS_DEPTH);

   logic [AW-1:0] mem [RAS_DEPTH];
   logic [PW-1:0] sp;     // next slot to write; top of stack is sp-1
   logic [PW:0]   count;

   assign full     = (count == (PW+1)'(RAS_DEPTH));
   assign empty    = (count == '0);
   assign ovf      = push & full;
   assign unf      = pop & empty;
   assign pop_data = mem[sp - PW'(1)];

   always_ff @(posedge clk) begin
      if (!rst) begin
         sp    <= '0;
         count <= '0;
      end else if (push) begin
         sp <= sp + PW'(1);
         if (!full) count <= count + (PW+1)'(1);
      end else if (pop && !empty) begin
         sp    <= sp - PW'(1);
         count <= count - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[sp] <= push_data;
   end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter unit: boot/interrupt vector fetch FSM, op sequencing,
// return-address stack and interrupt masking. All outputs are registered.
module pc_seq_unit
   import pc_seq_pkg::*;
#(
   parameter int unsigned AW           = 8,
   parameter int unsigned RAS_DEPTH    = 4,
   parameter int unsigned RST_VEC_ADDR = 0,
   parameter int unsigned INT_VEC_ADDR = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          irq,
   input  logic          en,
   input  logic          stall,
   input  logic [2:0]    op,
   input  logic [AW-1:0] target,
   input  logic [AW-1:0] vec_data,
   input  logic          vec_valid,
   output logic [AW-1:0] pc,
   output logic          pc_valid,
   output logic          vec_req,
   output logic [AW-1:0] vec_addr,
   output logic          int_ack,
   output logic          ras_ovf,
   output logic          ras_unf
);

   state_e        state;
   logic          int_mask;
   logic          take_int;
   logic          exec;
   logic          ras_push;
   logic          ras_pop;
   logic [AW-1:0] ras_push_data;
   logic [AW-1:0] ras_pop_data;
   logic          unused_full;
   logic          ras_empty;
   logic          ras_ovf_p;
   logic          ras_unf_p;

   always_comb begin
      take_int      = (state == RUN) && irq && !int_mask;
      exec          = (state == RUN) && en && !stall && !take_int;
      ras_push      = take_int || (exec && (op == OP_CALL));
      ras_pop       = exec && ((op == OP_RET) || (op == OP_RTI));
      // Interrupts save the un-stepped pc; CALL saves the return address.
      ras_push_data = take_int ? pc : pc + AW'(2);
   end

   pc_ras #(
      .AW        (AW),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (ras_push_data),
      .pop_data  (ras_pop_data),
      .full      (unused_full),
      .empty     (ras_empty),
      .ovf       (ras_ovf_p),
      .unf       (ras_unf_p)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= BOOT;
         pc       <= '0;
         pc_valid <= 1'b0;
         vec_req  <= 1'b0;
         vec_addr <= '0;
         int_ack  <= 1'b0;
         ras_ovf  <= 1'b0;
         ras_unf  <= 1'b0;
         int_mask <= 1'b0;
      end else begin
         int_ack <= 1'b0;
         if (ras_ovf_p) ras_ovf <= 1'b1;
         if (ras_unf_p) ras_unf <= 1'b1;
         case (state)
            BOOT: begin
               vec_req  <= 1'b1;
               vec_addr <= AW'(RST_VEC_ADDR);
               state    <= VEC;
            end
            VEC: begin
               if (vec_valid) begin
                  pc       <= vec_data;
                  pc_valid <= 1'b1;
                  vec_req  <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (take_int) begin
                  int_mask <= 1'b1;
                  int_ack  <= 1'b1;
                  pc_valid <= 1'b0;
                  vec_req  <= 1'b1;
                  vec_addr <= AW'(INT_VEC_ADDR);
                  state    <= VEC;
               end else if (exec) begin
                  case (op)
                     OP_INC1: pc <= pc + AW'(1);
                     OP_INC2: pc <= pc + AW'(2);
                     OP_JUMP: pc <= target;
                     OP_CALL: pc <= target;
                     OP_RET: begin
                        if (!ras_empty) pc <= ras_pop_data;
                     end
                     OP_RTI: begin
                        if (!ras_empty) pc <= ras_pop_data;
                        int_mask <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: directed scenarios plus randomized traffic, every
// cycle compared against a queue-based behavioural model.
module tb_pc_seq_unit;

   logic       clk = 1'b0;
   logic       rst, irq, en, stall, vec_valid;
   logic [2:0] op;
   logic [7:0] target, vec_data;
   logic [7:0] pc, vec_addr;
   logic       pc_valid, vec_req, int_ack, ras_ovf, ras_unf;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   int         m_phase;  // 0 booting, 1 waiting for vector word, 2 running
   logic [7:0] m_pc, m_vaddr;
   logic       m_valid, m_vreq, m_ack, m_ovf, m_unf, m_mask;
   logic [7:0] m_ras[$];

   always #5 clk = ~clk;

   pc_seq_unit #(
      .AW           (8),
      .RAS_DEPTH    (4),
      .RST_VEC_ADDR (0),
      .INT_VEC_ADDR (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .irq       (irq),
      .en        (en),
      .stall     (stall),
      .op        (op),
      .target    (target),
      .vec_data  (vec_data),
      .vec_valid (vec_valid),
      .pc        (pc),
      .pc_valid  (pc_valid),
      .vec_req   (vec_req),
      .vec_addr  (vec_addr),
      .int_ack   (int_ack),
      .ras_ovf   (ras_ovf),
      .ras_unf   (ras_unf)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_push(input logic [7:0] v);
      if (m_ras.size() == 4) begin
         void'(m_ras.pop_front());
         m_ovf = 1'b1;
      end
      m_ras.push_back(v);
   endtask

   task automatic model();
      if (!rst) begin
         m_phase = 0; m_pc = 0; m_valid = 0; m_vreq = 0; m_vaddr = 0;
         m_ack = 0; m_ovf = 0; m_unf = 0; m_mask = 0;
         m_ras.delete();
      end else begin
         m_ack = 0;
         if (m_phase == 0) begin
            m_vreq = 1; m_vaddr = 8'h00; m_phase = 1;
         end else if (m_phase == 1) begin
            if (vec_valid) begin
               m_pc = vec_data; m_valid = 1; m_vreq = 0; m_phase = 2;
            end
         end else if (irq && !m_mask) begin
            m_push(m_pc);
            m_mask = 1; m_ack = 1; m_valid = 0; m_vreq = 1; m_vaddr = 8'h01; m_phase = 1;
         end else if (en && !stall) begin
            if (op == 3'd1) m_pc = m_pc + 8'd1;
            else if (op == 3'd2) m_pc = m_pc + 8'd2;
            else if (op == 3'd3) m_pc = target;
            else if (op == 3'd4) begin
               m_push(m_pc + 8'd2);
               m_pc = target;
            end else if (op == 3'd5 || op == 3'd6) begin
               if (m_ras.size() == 0) m_unf = 1;
               else m_pc = m_ras.pop_back();
               if (op == 3'd6) m_mask = 0;
            end
         end
      end
   endtask

   // Apply current inputs for one edge and compare every output to the model.
   task automatic step();
      model();
      @(posedge clk);
      #1;
      chk("pc", pc, m_pc);
      chk("pc_valid", {7'd0, pc_valid}, {7'd0, m_valid});
      chk("vec_req", {7'd0, vec_req}, {7'd0, m_vreq});
      chk("vec_addr", vec_addr, m_vaddr);
      chk("int_ack", {7'd0, int_ack}, {7'd0, m_ack});
      chk("ras_ovf", {7'd0, ras_ovf}, {7'd0, m_ovf});
      chk("ras_unf", {7'd0, ras_unf}, {7'd0, m_unf});
   endtask

   task automatic run_op(input logic [2:0] o, input logic [7:0] t);
      op = o; target = t;
      step();
   endtask

   task automatic do_reset_boot(input logic [7:0] vd);
      rst = 0; irq = 0; en = 1; stall = 0; op = 3'd0; vec_valid = 1; vec_data = vd;
      step();
      rst = 1;
      step();
      step();
   endtask

   initial begin
      rst = 0; irq = 0; en = 1; stall = 0; op = 3'd0; target = 0;
      vec_valid = 0; vec_data = 0;

      // 1: reset state and boot vector latency
      step();
      chk("rst_pc", pc, 8'h00);
      chk("rst_valid", {7'd0, pc_valid}, 8'd0);
      chk("rst_vreq", {7'd0, vec_req}, 8'd0);
      rst = 1; vec_valid = 1; vec_data = 8'h20;
      step();
      chk("boot_vreq", {7'd0, vec_req}, 8'd1);
      chk("boot_vaddr", vec_addr, 8'h00);
      chk("boot_valid", {7'd0, pc_valid}, 8'd0);
      step();
      chk("boot_pc", pc, 8'h20);
      chk("boot_pc_valid", {7'd0, pc_valid}, 8'd1);
      vec_valid = 0;

      // 2: increments, jump, wrap
      run_op(3'd1, 8'h00); chk("inc1", pc, 8'h21);
      run_op(3'd2, 8'h00); chk("inc2", pc, 8'h23);
      run_op(3'd3, 8'h80); chk("jump", pc, 8'h80);
      run_op(3'd3, 8'hFF);
      run_op(3'd2, 8'h00); chk("inc2_wrap", pc, 8'h01);

      // 3: call/return and underflow
      run_op(3'd3, 8'h10);
      run_op(3'd4, 8'h40); chk("call", pc, 8'h40);
      run_op(3'd5, 8'h00); chk("ret", pc, 8'h12);
      run_op(3'd5, 8'h00); chk("ret_empty_pc", pc, 8'h12);
      chk("ret_empty_unf", {7'd0, ras_unf}, 8'd1);

      // 4: interrupt under stall, masking, RTI and retake
      run_op(3'd3, 8'h30);
      irq = 1; stall = 1; run_op(3'd3, 8'h55);
      chk("irq_ack", {7'd0, int_ack}, 8'd1);
      chk("irq_vaddr", vec_addr, 8'h01);
      chk("irq_pc_hold", pc, 8'h30);
      irq = 0; stall = 0; vec_valid = 1; vec_data = 8'h90;
      run_op(3'd0, 8'h00); chk("isr_pc", pc, 8'h90);
      irq = 1; vec_valid = 0;
      run_op(3'd1, 8'h00); chk("masked_ack", {7'd0, int_ack}, 8'd0);
      run_op(3'd6, 8'h00); chk("rti_pc", pc, 8'h30);
      run_op(3'd0, 8'h00); chk("retake_ack", {7'd0, int_ack}, 8'd1);
      irq = 0; vec_valid = 1; vec_data = 8'h90;
      run_op(3'd0, 8'h00);
      vec_valid = 0;
      run_op(3'd6, 8'h00); chk("rti2_pc", pc, 8'h30);

      // 5: RAS overflow, LIFO order of newest four, then underflow
      do_reset_boot(8'h00);
      run_op(3'd4, 8'h10);
      run_op(3'd4, 8'h20);
      run_op(3'd4, 8'h30);
      run_op(3'd4, 8'h40);
      chk("ovf_before", {7'd0, ras_ovf}, 8'd0);
      run_op(3'd4, 8'h50);
      chk("ovf_after", {7'd0, ras_ovf}, 8'd1);
      run_op(3'd5, 8'h00); chk("lifo0", pc, 8'h42);
      run_op(3'd5, 8'h00); chk("lifo1", pc, 8'h32);
      run_op(3'd5, 8'h00); chk("lifo2", pc, 8'h22);
      run_op(3'd5, 8'h00); chk("lifo3", pc, 8'h12);
      chk("unf_before", {7'd0, ras_unf}, 8'd0);
      run_op(3'd5, 8'h00); chk("lifo_empty_pc", pc, 8'h12);
      chk("unf_after", {7'd0, ras_unf}, 8'd1);

      // 6: reset in the middle of an interrupt vector fetch
      irq = 1; vec_valid = 0;
      run_op(3'd0, 8'h00);
      rst = 0; irq = 0;
      step();
      chk("midvec_valid", {7'd0, pc_valid}, 8'd0);
      chk("midvec_vreq", {7'd0, vec_req}, 8'd0);
      chk("midvec_unf", {7'd0, ras_unf}, 8'd0);
      chk("midvec_ovf", {7'd0, ras_ovf}, 8'd0);
      rst = 1; vec_valid = 1; vec_data = 8'h44;
      step();
      step();
      vec_valid = 0;
      run_op(3'd5, 8'h00); chk("midvec_ras_empty", {7'd0, ras_unf}, 8'd1);
      chk("midvec_pc", pc, 8'h44);
      irq = 1;
      run_op(3'd0, 8'h00); chk("midvec_unmasked", {7'd0, int_ack}, 8'd1);
      irq = 0;

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 99) != 0);
         irq       = ($urandom_range(0, 7) == 0);
         en        = ($urandom_range(0, 3) != 0);
         stall     = ($urandom_range(0, 3) == 0);
         op        = 3'($urandom_range(0, 7));
         target    = 8'($urandom);
         vec_valid = ($urandom_range(0, 2) == 0);
         vec_data  = 8'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
